// File: rtl/encoder_8_3_queued_if.sv
// Request/response bundle for the queued 8-to-3 encoder: request strobes in,
// one encoded index at a time out over valid/ready, plus the pending snapshot.
interface encoder_8_3_queued_if;
    logic       E;
    logic [7:0] In;
    logic [2:0] Out;
    logic       Valid;
    logic       Ready;
    logic [7:0] Pend;

    modport master (
        output E,
        output In,
        output Ready,
        input  Out,
        input  Valid,
        input  Pend
    );

    modport slave (
        input  E,
        input  In,
        input  Ready,
        output Out,
        output Valid,
        output Pend
    );
endinterface

// File: rtl/encoder_8_3_queued.sv
// Sequential 8-to-3 priority encoder: request pulses collect in a pending
// register and are handed out highest index first, one per accepted handshake.
module encoder_8_3_queued (
    input  logic                        clk,
    input  logic                        rst,
    encoder_8_3_queued_if.slave         bus
);

    logic [7:0] pend_p0;
    logic [2:0] out_p0;
    logic       vld_p0;

    logic       acc;
    logic [7:0] clr;
    logic [7:0] cap;
    logic [7:0] pend_next;

    // Highest set bit wins; an all-zero vector encodes as 0.
    function automatic logic [2:0] prio_enc(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    always_comb begin
        acc       = vld_p0 && bus.Ready;
        clr       = acc ? (8'h01 << out_p0) : 8'h00;
        cap       = bus.E ? bus.In : 8'h00;
        // Capture is ORed after the clear, so a same-cycle re-request survives.
        pend_next = (pend_p0 & ~clr) | cap;
    end

    // Stage p0: pending register and presented code
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_p0 <= 8'h00;
            out_p0  <= 3'd0;
            vld_p0  <= 1'b0;
        end else begin
            pend_p0 <= pend_next;
            // A presented code is held until taken; no preemption by newer requests.
            if (!vld_p0 || acc) begin
                vld_p0 <= |pend_next;
                out_p0 <= prio_enc(pend_next);
            end
        end
    end

    assign bus.Pend  = pend_p0;
    assign bus.Out   = out_p0;
    assign bus.Valid = vld_p0;

endmodule

// File: tb/tb_encoder_8_3_queued.sv
// Bench for encoder_8_3_queued: directed vectors, accepted codes checked
// against a queue of hand-computed expectations by an independent monitor.
module tb_encoder_8_3_queued;

    logic clk;
    logic rst;

    encoder_8_3_queued_if bus();

    encoder_8_3_queued dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [2:0] sb[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic v, input logic [2:0] o, input logic [7:0] p);
        chk({name, ".Valid"}, {7'd0, bus.Valid}, {7'd0, v});
        chk({name, ".Out"},   {5'd0, bus.Out},   {5'd0, o});
        chk({name, ".Pend"},  bus.Pend,          p);
    endtask

    // Monitor: every acceptance pops one expected code; also checks Pend[Out] while Valid.
    always @(negedge clk) begin
        if (!rst && bus.Valid) begin
            checks++;
            if (bus.Pend[bus.Out] !== 1'b1) begin
                failures++;
                $display("FAIL invariant: Pend=%0h Out=%0d", bus.Pend, bus.Out);
            end
            if (bus.Ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL accept_unexpected: got Out=%0d expected no acceptance", bus.Out);
                end else begin
                    logic [2:0] e;
                    e = sb.pop_front();
                    if (bus.Out !== e) begin
                        failures++;
                        $display("FAIL accept_code: got %0d expected %0d", bus.Out, e);
                    end
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; bus.E = 1'b1; bus.In = 8'hFF; bus.Ready = 1'b0;

        // Reset wins over a full request vector
        tick(); tick();
        chk_out("reset", 1'b0, 3'd0, 8'h00);
        rst = 1'b0; bus.In = 8'h00;
        tick();
        chk_out("idle1", 1'b0, 3'd0, 8'h00);
        tick();
        chk_out("idle2", 1'b0, 3'd0, 8'h00);

        // Single request held without Ready, then accepted
        bus.In = 8'h20; sb.push_back(3'd5);
        tick(); bus.In = 8'h00;
        chk_out("single", 1'b1, 3'd5, 8'h20);
        repeat (5) tick();
        chk_out("single_hold", 1'b1, 3'd5, 8'h20);
        bus.Ready = 1'b1;
        tick(); bus.Ready = 1'b0;
        chk_out("single_done", 1'b0, 3'd0, 8'h00);

        // Priority drain with Ready held high
        bus.In = 8'hA5; bus.Ready = 1'b1;
        sb.push_back(3'd7); sb.push_back(3'd5); sb.push_back(3'd2); sb.push_back(3'd0);
        tick(); bus.In = 8'h00;
        chk_out("drain0", 1'b1, 3'd7, 8'hA5);
        tick(); chk_out("drain1", 1'b1, 3'd5, 8'h25);
        tick(); chk_out("drain2", 1'b1, 3'd2, 8'h05);
        tick(); chk_out("drain3", 1'b1, 3'd0, 8'h01);
        tick(); chk_out("drain4", 1'b0, 3'd0, 8'h00);
        bus.Ready = 1'b0;

        // No preemption by a later higher-priority request
        bus.In = 8'h02; sb.push_back(3'd1); sb.push_back(3'd7);
        tick(); bus.In = 8'h00;
        chk_out("nopre0", 1'b1, 3'd1, 8'h02);
        bus.In = 8'h80;
        tick(); bus.In = 8'h00;
        chk_out("nopre1", 1'b1, 3'd1, 8'h82);
        bus.Ready = 1'b1;
        tick(); bus.Ready = 1'b0;
        chk_out("nopre2", 1'b1, 3'd7, 8'h80);
        bus.Ready = 1'b1;
        tick(); bus.Ready = 1'b0;
        chk_out("nopre3", 1'b0, 3'd0, 8'h00);

        // Set beats clear
        bus.In = 8'h08; sb.push_back(3'd3); sb.push_back(3'd3);
        tick(); bus.In = 8'h00;
        chk_out("sbc0", 1'b1, 3'd3, 8'h08);
        bus.Ready = 1'b1; bus.In = 8'h08;
        tick(); bus.Ready = 1'b0; bus.In = 8'h00;
        chk_out("sbc1", 1'b1, 3'd3, 8'h08);
        bus.Ready = 1'b1;
        tick(); bus.Ready = 1'b0;
        chk_out("sbc2", 1'b0, 3'd0, 8'h00);

        // Enable gating while draining
        bus.In = 8'h0C; sb.push_back(3'd3); sb.push_back(3'd2);
        tick();
        chk_out("en0", 1'b1, 3'd3, 8'h0C);
        bus.E = 1'b0; bus.In = 8'h40; bus.Ready = 1'b1;
        tick(); chk_out("en1", 1'b1, 3'd2, 8'h04);
        tick(); chk_out("en2", 1'b0, 3'd0, 8'h00);
        bus.E = 1'b1; bus.In = 8'h00; bus.Ready = 1'b0;

        // Reset mid-handshake discards everything
        bus.In = 8'hF0;
        tick(); bus.In = 8'h00;
        chk_out("rstmid0", 1'b1, 3'd7, 8'hF0);
        rst = 1'b1;
        tick(); rst = 1'b0;
        chk_out("rstmid1", 1'b0, 3'd0, 8'h00);
        tick();
        chk_out("rstmid2", 1'b0, 3'd0, 8'h00);

        chk("sb_empty", 8'(sb.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
